// File: rtl/dmem_dbg_arbiter_pkg.sv
// Shared definitions for the data-memory port: access size codes and the
// debug dump sequencer states.
package dmem_dbg_arbiter_pkg;

  // Access size codes on the memory bhw lines (also used by the MEM stage).
  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b011;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;
  localparam logic [2:0] BHW_WU = 3'b111;

  // Dump sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_HOLD,
    ST_DONE
  } dbg_state_e;

endpackage

// File: rtl/dmem_port_mux.sv
// Drives the data-memory port from either the CPU MEM stage or the debug
// dump engine. The debug side only ever issues full-word reads.
module dmem_port_mux
  import dmem_dbg_arbiter_pkg::*;
#(
  parameter int NB_WIDTH = 32
) (
  input  logic                dbg_sel,
  input  logic [NB_WIDTH-1:0] cpu_addr,
  input  logic [NB_WIDTH-1:0] cpu_wdata,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [2:0]          cpu_bhw,
  input  logic [NB_WIDTH-1:0] dbg_addr,
  output logic [NB_WIDTH-1:0] mem_addr,
  output logic [NB_WIDTH-1:0] mem_wdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [2:0]          mem_bhw
);

  // Select the port owner; a debug slot suppresses any CPU store or load.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = cpu_read;
    mem_write = cpu_write;
    mem_bhw   = cpu_bhw;
    if (dbg_sel) begin
      mem_addr  = dbg_addr;
      mem_wdata = '0;
      mem_read  = 1'b1;
      mem_write = 1'b0;
      mem_bhw   = BHW_W;
    end
  end

endmodule

// File: rtl/dmem_dbg_arbiter.sv
// Shares the data-memory port between the CPU MEM stage (always preferred)
// and a burst-dump engine that streams N consecutive words to the UART side.
// A starvation counter steals one CPU cycle after MAX_WAIT blocked cycles.
module dmem_dbg_arbiter
  import dmem_dbg_arbiter_pkg::*;
#(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9,
  parameter int MAX_WAIT = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_WIDTH-1:0] i_cpu_addr,
  input  logic [NB_WIDTH-1:0] i_cpu_wdata,
  input  logic                i_cpu_read,
  input  logic                i_cpu_write,
  input  logic [2:0]          i_cpu_bhw,
  output logic [NB_WIDTH-1:0] o_cpu_rdata,
  output logic                o_cpu_stall,
  input  logic                i_dbg_start,
  input  logic [NB_ADDR-1:0]  i_dbg_base,
  input  logic [NB_ADDR-2:0]  i_dbg_count,
  input  logic                i_dbg_ready,
  output logic [NB_WIDTH-1:0] o_dbg_data,
  output logic                o_dbg_valid,
  output logic                o_dbg_busy,
  output logic                o_dbg_done,
  output logic [NB_WIDTH-1:0] o_mem_addr,
  output logic [NB_WIDTH-1:0] o_mem_wdata,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic [2:0]          o_mem_bhw,
  input  logic [NB_WIDTH-1:0] i_mem_rdata
);

  localparam int NB_WAIT = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int NB_CNT  = NB_ADDR - 1;

  dbg_state_e          state;
  logic [NB_ADDR-1:0]  addr;
  logic [NB_CNT-1:0]   remaining;
  logic [NB_WAIT-1:0]  wait_cnt;
  logic                cpu_busy;
  logic                dbg_slot;

  assign cpu_busy    = i_cpu_read | i_cpu_write;
  // Take the port when the CPU leaves it free, or force it once starved.
  assign dbg_slot    = (state == ST_ARB) &&
                       (!cpu_busy || (wait_cnt == NB_WAIT'(MAX_WAIT)));
  assign o_cpu_stall = dbg_slot & cpu_busy;
  assign o_cpu_rdata = i_mem_rdata;
  assign o_dbg_busy  = (state != ST_IDLE);

  dmem_port_mux #(.NB_WIDTH(NB_WIDTH)) u_mux (
    .dbg_sel   (dbg_slot),
    .cpu_addr  (i_cpu_addr),
    .cpu_wdata (i_cpu_wdata),
    .cpu_read  (i_cpu_read),
    .cpu_write (i_cpu_write),
    .cpu_bhw   (i_cpu_bhw),
    .dbg_addr  (NB_WIDTH'(addr)),
    .mem_addr  (o_mem_addr),
    .mem_wdata (o_mem_wdata),
    .mem_read  (o_mem_read),
    .mem_write (o_mem_write),
    .mem_bhw   (o_mem_bhw)
  );

  // Dump sequencer: address/count stepping, starvation count, output register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remaining   <= '0;
      wait_cnt    <= '0;
      o_dbg_data  <= '0;
      o_dbg_valid <= 1'b0;
      o_dbg_done  <= 1'b0;
    end else begin
      o_dbg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_dbg_start) begin
            if (i_dbg_count != '0) begin
              addr      <= i_dbg_base & ~NB_ADDR'(3);
              remaining <= i_dbg_count;
              wait_cnt  <= '0;
              state     <= ST_ARB;
            end else begin
              o_dbg_done <= 1'b1;
            end
          end
        end
        ST_ARB: begin
          if (dbg_slot) begin
            o_dbg_data  <= i_mem_rdata;
            o_dbg_valid <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            wait_cnt <= wait_cnt + NB_WAIT'(1);
          end
        end
        ST_HOLD: begin
          if (i_dbg_ready) begin
            o_dbg_valid <= 1'b0;
            addr        <= addr + NB_ADDR'(4);
            remaining   <= remaining - NB_CNT'(1);
            if (remaining == NB_CNT'(1)) begin
              state      <= ST_DONE;
              o_dbg_done <= 1'b1;
            end else begin
              state    <= ST_ARB;
              wait_cnt <= '0;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dbg_arbiter.sv
// Scoreboard bench for dmem_dbg_arbiter: directed dumps plus random CPU and
// debug traffic, checked against a word-level dump model and a memory array.
module tb_dmem_dbg_arbiter;

  localparam int NB_WIDTH = 32;
  localparam int NB_ADDR  = 9;
  localparam int MAX_WAIT = 4;

  logic                i_clk = 1'b0;
  logic                i_reset;
  logic [NB_WIDTH-1:0] i_cpu_addr, i_cpu_wdata;
  logic                i_cpu_read, i_cpu_write;
  logic [2:0]          i_cpu_bhw;
  logic [NB_WIDTH-1:0] o_cpu_rdata;
  logic                o_cpu_stall;
  logic                i_dbg_start;
  logic [NB_ADDR-1:0]  i_dbg_base;
  logic [NB_ADDR-2:0]  i_dbg_count;
  logic                i_dbg_ready;
  logic [NB_WIDTH-1:0] o_dbg_data;
  logic                o_dbg_valid, o_dbg_busy, o_dbg_done;
  logic [NB_WIDTH-1:0] o_mem_addr, o_mem_wdata;
  logic                o_mem_read, o_mem_write;
  logic [2:0]          o_mem_bhw;
  logic [NB_WIDTH-1:0] i_mem_rdata;

  logic [31:0] mem [0:127];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    bit          last;
  } exp_t;
  exp_t q[$];

  // Model state: which phase of a word the dump should be in.
  bit          in_arb, mvalid, mbusy, done_due, held_v;
  int          w;
  logic [31:0] held;

  dmem_dbg_arbiter #(.NB_WIDTH(NB_WIDTH), .NB_ADDR(NB_ADDR), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .i_cpu_read(i_cpu_read), .i_cpu_write(i_cpu_write), .i_cpu_bhw(i_cpu_bhw),
    .o_cpu_rdata(o_cpu_rdata), .o_cpu_stall(o_cpu_stall),
    .i_dbg_start(i_dbg_start), .i_dbg_base(i_dbg_base), .i_dbg_count(i_dbg_count),
    .i_dbg_ready(i_dbg_ready), .o_dbg_data(o_dbg_data), .o_dbg_valid(o_dbg_valid),
    .o_dbg_busy(o_dbg_busy), .o_dbg_done(o_dbg_done),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_bhw(o_mem_bhw),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Word-addressed memory behind the port: combinational read, clocked write.
  assign i_mem_rdata = o_mem_read ? mem[o_mem_addr[NB_ADDR-1:2]] : 32'h0;
  always @(posedge i_clk) if (o_mem_write) mem[o_mem_addr[NB_ADDR-1:2]] <= o_mem_wdata;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // Monitor: predicts every cycle from the dump rules, pops on handshakes.
  always @(negedge i_clk) begin
    bit   slot, cpu_act, hs, busy_now, nd;
    exp_t e;
    int   a;
    cpu_act = i_cpu_read | i_cpu_write;
    chk("cpu_rdata", o_cpu_rdata, i_mem_rdata);
    if (i_reset) begin
      chk("rst_flags", {o_dbg_valid, o_dbg_done, o_dbg_busy, o_cpu_stall}, 4'b0);
      chk("rst_data", o_dbg_data, 32'h0);
      chk("rst_mux", {o_mem_read, o_mem_write, o_mem_addr}, {i_cpu_read, i_cpu_write, i_cpu_addr});
      q.delete();
      in_arb = 0; mvalid = 0; mbusy = 0; done_due = 0; held_v = 0; w = 0;
    end else begin
      slot = in_arb && (!cpu_act || w == MAX_WAIT);
      hs   = mvalid && i_dbg_ready;
      chk("stall", o_cpu_stall, slot && cpu_act);
      chk("valid", o_dbg_valid, mvalid);
      chk("busy", o_dbg_busy, mbusy);
      chk("done", o_dbg_done, done_due);
      if (slot) begin
        if (q.size() == 0) chk("slot_queue", 0, 1);
        else chk("slot_port", {o_mem_read, o_mem_write, o_mem_bhw, o_mem_addr},
                 {1'b1, 1'b0, 3'b011, 23'h0, q[0].addr});
      end else begin
        chk("cpu_port", {o_mem_read, o_mem_write, o_mem_bhw, o_mem_addr, o_mem_wdata},
            {i_cpu_read, i_cpu_write, i_cpu_bhw, i_cpu_addr, i_cpu_wdata});
      end
      if (held_v) chk("hold_data", o_dbg_data, held);
      held_v = o_dbg_valid && !i_dbg_ready;
      held   = o_dbg_data;

      nd = 0;
      busy_now = mbusy;
      if (slot) begin in_arb = 0; mvalid = 1; end
      else if (in_arb) w++;
      if (hs) begin
        mvalid = 0;
        if (q.size() == 0) chk("hs_queue", 0, 1);
        else begin
          e = q.pop_front();
          chk("dbg_data", o_dbg_data, e.data);
          if (e.last) nd = 1;
          else begin in_arb = 1; w = 0; end
        end
      end
      if (done_due && busy_now) mbusy = 0;
      if (i_dbg_start && !busy_now) begin
        if (i_dbg_count == 0) nd = 1;
        else begin
          for (int i = 0; i < int'(i_dbg_count); i++) begin
            a = ((int'(i_dbg_base) & ~3) + 4 * i) % 512;
            e.addr = 9'(a);
            e.data = mem[a / 4];
            e.last = (i == int'(i_dbg_count) - 1);
            q.push_back(e);
          end
          mbusy = 1; in_arb = 1; w = 0;
        end
      end
      done_due = nd;
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic cpu_idle();
    i_cpu_read = 0; i_cpu_write = 0;
  endtask

  task automatic cpu_store(input int a, input logic [31:0] d);
    i_cpu_addr = 32'(a); i_cpu_wdata = d; i_cpu_bhw = 3'b011;
    i_cpu_read = 0; i_cpu_write = 1;
    tick();
    cpu_idle();
  endtask

  task automatic start_dump(input int base, input int cnt);
    i_dbg_base = 9'(base); i_dbg_count = 8'(cnt); i_dbg_start = 1;
    tick();
    i_dbg_start = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((mbusy || done_due || mvalid) && n < budget) begin tick(); n++; end
    if (mbusy || done_due || mvalid) chk("drain_timeout", n, 0);
  endtask

  initial begin
    int nst, sidx, r;
    i_reset = 1; i_cpu_addr = 0; i_cpu_wdata = 0; i_cpu_bhw = 3'b011;
    i_cpu_read = 0; i_cpu_write = 0; i_dbg_start = 0; i_dbg_base = 0;
    i_dbg_count = 0; i_dbg_ready = 1;
    repeat (3) tick();
    i_reset = 0;
    tick();

    // Preload through the CPU path.
    for (int i = 0; i < 128; i++) cpu_store(4 * i, 32'h1000_0000 + 32'(i * 7));
    cpu_store(32'h000, 32'h0000_0001);
    cpu_store(32'h010, 32'h1234_5678);
    cpu_store(32'h014, 32'hCAFE_F00D);
    cpu_store(32'h020, 32'hDEAD_BEEF);
    cpu_store(32'h1FC, 32'hA1A2_A3A4);

    // Dump with CPU idle.
    i_dbg_ready = 1;
    start_dump(32'h10, 2);
    wait_idle(50);

    // CPU storing every cycle: one forced slot on the (MAX_WAIT+1)th ARB cycle.
    i_cpu_addr = 32'h100; i_cpu_wdata = 32'h5A5A_0001; i_cpu_bhw = 3'b011;
    i_cpu_read = 0; i_cpu_write = 1;
    i_dbg_base = 9'h20; i_dbg_count = 8'd1; i_dbg_start = 1;
    nst = 0; sidx = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      if (o_cpu_stall) begin nst++; sidx = i; end
      @(posedge i_clk); #1;
      i_dbg_start = 0;
    end
    chk("sat_stall_count", nst, 1);
    chk("sat_stall_pos", sidx, MAX_WAIT + 1);
    cpu_idle();
    wait_idle(50);

    // Backpressure while the CPU keeps reading word 0.
    i_dbg_ready = 0;
    start_dump(32'h30, 1);
    tick(); tick();
    i_cpu_addr = 32'h0; i_cpu_read = 1; i_cpu_bhw = 3'b011;
    repeat (6) begin
      @(negedge i_clk);
      chk("bp_cpu_rdata", o_cpu_rdata, 32'h1);
      chk("bp_valid", o_dbg_valid, 1'b1);
      @(posedge i_clk); #1;
    end
    cpu_idle();
    i_dbg_ready = 1;
    wait_idle(50);

    // Unaligned base near the top wraps to 0x000.
    start_dump(32'h1FE, 2);
    wait_idle(50);

    // Zero count: done pulse only.
    start_dump(32'h40, 0);
    wait_idle(10);

    // Start while busy is ignored.
    start_dump(32'h50, 3);
    start_dump(32'h60, 2);
    wait_idle(50);

    // Reset mid-dump drops the dump silently.
    i_dbg_ready = 0;
    start_dump(32'h70, 4);
    repeat (4) tick();
    i_reset = 1;
    tick(); tick();
    i_reset = 0;
    i_dbg_ready = 1;
    repeat (4) tick();

    // Random CPU and debug traffic.
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 9);
      i_cpu_read  = (r < 3);
      i_cpu_write = (r >= 3 && r < 6);
      i_cpu_addr  = i_cpu_write ? 32'(32'h100 + 4 * $urandom_range(0, 15))
                                : 32'(4 * $urandom_range(0, 127));
      i_cpu_wdata = $urandom;
      i_cpu_bhw   = 3'b011;
      i_dbg_ready = ($urandom_range(0, 3) != 0);
      i_dbg_start = ($urandom_range(0, 7) == 0);
      i_dbg_base  = 9'($urandom_range(0, 'hBF));
      i_dbg_count = 8'($urandom_range(0, 8));
      tick();
    end
    cpu_idle();
    i_dbg_start = 0;
    i_dbg_ready = 1;
    wait_idle(200);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
